dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data-memory requests (memRd/memWr, 16-bit address and write data).
- Holds a single-ported word array and services one request at a time with a fixed, parameterised latency.
- Returns read data with a one-cycle rsp_valid pulse.
- Drives busy so the core can stall while an access is in flight.

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for MEM-stage data-memory requests. It holds a
//   single-ported array of 2^ADDR_W 16-bit words and services one request at
//   a time. Every request takes a fixed LAT cycles in WAIT. The response is a
//   one-cycle rsp_valid pulse.
//
//   Handshake: the requester raises req_rd and/or req_wr and holds them,
//   together with address and data, until it samples rsp_valid=1. A request
//   is accepted only in IDLE. Request inputs are ignored in WAIT and RESP.
//   If both strobes are high, the request is a write. Every access is
//   read-before-write, so rsp_rd_data always carries the old contents.
//
//   Parameters:
//     ADDR_W  word-address bits implemented (ADDR_W < 16)
//     LAT     cycles spent in WAIT; legal range 1..15
//
//   Optional feature (macro DMEM_RANGE_CHK_EN):
//     Adds the rsp_err port. A request whose address has any bit set above
//     ADDR_W is flagged. A flagged request does not touch the array and
//     returns zero data. Timing is the same in both builds.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     req_rd       in   read request
//     req_wr       in   write request
//     req_addr     in   16-bit word address
//     req_wr_data  in   16-bit write data
//     rsp_valid    out  one-cycle completion pulse
//     rsp_rd_data  out  read data (old contents), held until next response
//     busy         out  high while the request sits in WAIT
//     rsp_err      out  out-of-range flag, qualified by rsp_valid
//                       (DMEM_RANGE_CHK_EN only)
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wr_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_rd_data,
    output logic        busy
`ifdef DMEM_RANGE_CHK_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wr_data;
    logic                r_op_wr;
    logic                r_oor;
    logic [15:0]         r_rd_data;
    logic [15:0]         r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_access;
    logic                w_oor;

    assign w_accept = (r_state == ST_IDLE) && (req_rd || req_wr);
    // The access happens on the last WAIT edge, when the counter has run out.
    assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_RANGE_CHK_EN
    assign w_oor = |(req_addr >> ADDR_W);
`else
    // Upper address bits alias onto the implemented range.
    logic w_unused_upper;
    assign w_unused_upper = ^req_addr[15:ADDR_W];
    assign w_oor          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (req_rd || req_wr) w_next_state = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)    w_next_state = ST_RESP;
            ST_RESP:                       w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decode the registered state directly.
    always_comb begin
        rsp_valid = (r_state == ST_RESP);
        busy      = (r_state == ST_WAIT);
`ifdef DMEM_RANGE_CHK_EN
        rsp_err   = (r_state == ST_RESP) && r_oor;
`endif
    end

    assign rsp_rd_data = r_rd_data;

    // Request latch, latency counter and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wr_data <= 16'h0000;
            r_op_wr   <= 1'b0;
            r_oor     <= 1'b0;
            r_rd_data <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_cnt     <= 4'(LAT - 1);
                r_addr    <= req_addr[ADDR_W-1:0];
                r_wr_data <= req_wr_data;
                r_op_wr   <= req_wr;
                r_oor     <= w_oor;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rd_data <= r_oor ? 16'h0000 : r_mem[r_addr];
            end
        end
    end

    // The array has no reset. A reset during WAIT returns the FSM to IDLE
    // at once, so an aborted write never reaches this port.
    always_ff @(posedge clk) begin
        if (w_access && r_op_wr && !r_oor) begin
            r_mem[r_addr] <= r_wr_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        rst_n;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wr_data;
    logic        rsp_valid;
    logic [15:0] rsp_rd_data;
    logic        busy;
    logic        rsp_err;

    int n_checks;
    int n_errors;

    // Reference model: word array plus a "has been written" flag per word.
    logic [15:0] model_mem   [0:DEPTH-1];
    bit          model_known [0:DEPTH-1];
    logic [15:0] last_rsp;
    bit          last_known;

    dmem_responder #(
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .rsp_valid   (rsp_valid),
        .rsp_rd_data (rsp_rd_data),
        .busy        (busy)
`ifdef DMEM_RANGE_CHK_EN
        ,
        .rsp_err     (rsp_err)
`endif
    );

`ifndef DMEM_RANGE_CHK_EN
    assign rsp_err = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request in an IDLE cycle and follow it to its response.
    task automatic run_req(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input string tag);
        int          idx;
        bit          oor;
        bit          exp_known;
        logic [15:0] exp_rd;
        int          k;
        bit          got;

        idx = int'(addr) % DEPTH;
`ifdef DMEM_RANGE_CHK_EN
        oor = (int'(addr) >= DEPTH);
`else
        oor = 1'b0;
`endif
        if (oor) begin
            exp_rd    = 16'h0000;
            exp_known = 1'b1;
        end else begin
            exp_rd    = model_mem[idx];
            exp_known = model_known[idx];
            if (wr) begin
                model_mem[idx]   = data;
                model_known[idx] = 1'b1;
            end
        end

        @(posedge clk); #1;
        check({tag, "_idle_busy"}, busy, 0);
        req_rd      = rd;
        req_wr      = wr;
        req_addr    = addr;
        req_wr_data = data;

        k   = 0;
        got = 1'b0;
        while (k < LAT + 6 && !got) begin
            @(posedge clk); #1;
            k++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (k <= LAT) check({tag, "_busy"}, busy, 1);
                if (last_known) check({tag, "_hold"}, rsp_rd_data, last_rsp);
            end
        end
        check({tag, "_latency"}, k, LAT + 1);
        if (got) begin
            check({tag, "_resp_busy"}, busy, 0);
            if (exp_known) check({tag, "_data"}, rsp_rd_data, exp_rd);
`ifdef DMEM_RANGE_CHK_EN
            check({tag, "_err"}, rsp_err, oor);
`endif
        end
        req_rd = 1'b0;
        req_wr = 1'b0;
        last_rsp   = exp_rd;
        last_known = exp_known;

        @(posedge clk); #1;
        check({tag, "_pulse_end"}, rsp_valid, 0);
        if (last_known) check({tag, "_after_hold"}, rsp_rd_data, last_rsp);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        req_rd      = 1'b0;
        req_wr      = 1'b0;
        req_addr    = 16'h0000;
        req_wr_data = 16'h0000;
        last_rsp    = 16'h0000;
        last_known  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 16'h0000;
            model_known[i] = 1'b0;
        end

        // Reset values
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_data",  rsp_rd_data, 16'h0000);
`ifdef DMEM_RANGE_CHK_EN
        check("rst_err",   rsp_err, 0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", busy, 0);

        // Write then read
        run_req(1'b0, 1'b1, 16'h0005, 16'hBEEF, "wr5");
        run_req(1'b1, 1'b0, 16'h0005, 16'h0000, "rd5");
        check("rd5_value", last_rsp, 16'hBEEF);

        // Simultaneous read+write acts as a write, returns old data
        run_req(1'b1, 1'b1, 16'h0005, 16'h1234, "rdwr5");
        run_req(1'b1, 1'b0, 16'h0005, 16'h0000, "rd5b");

        // Reset in the middle of WAIT aborts the write
        run_req(1'b0, 1'b1, 16'h0007, 16'h7777, "wr7");
        @(posedge clk); #1;
        req_wr      = 1'b1;
        req_addr    = 16'h0007;
        req_wr_data = 16'hAAAA;
        @(posedge clk); #1;
        check("abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_rst",  busy, 0);
        check("abort_valid_rst", rsp_valid, 0);
        check("abort_data_rst",  rsp_rd_data, 16'h0000);
        req_wr = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", rsp_valid, 0);
        end
        rst_n      = 1'b1;
        last_rsp   = 16'h0000;
        last_known = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid_post", rsp_valid, 0);
        end
        run_req(1'b1, 1'b0, 16'h0007, 16'h0000, "rd7");

        // Upper address bits: aliasing, or range error with the check built in
        run_req(1'b0, 1'b1, 16'h0405, 16'h5A5A, "wr405");
        run_req(1'b1, 1'b0, 16'h0005, 16'h0000, "rd5c");

        // Fill a small window so random reads have known data
        for (int a = 0; a < 32; a++) begin
            run_req(1'b0, 1'b1, 16'(a), 16'($urandom), "fill");
        end

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            logic        rd;
            logic        wr;
            a = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) a[15:ADDR_W] = 6'($urandom_range(1, 63));
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            run_req(rd, wr, a, 16'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
